// File: rtl/syncgen_pkg.sv
// Shared types and constants for the programmable sync generator.
// Timing fields are carried at TMG_W bits; generator instances must use CNT_W <= TMG_W.
package syncgen_pkg;

    typedef enum logic {
        SG_IDLE   = 1'b0,
        SG_ACTIVE = 1'b1
    } sg_state_e;

    localparam int TMG_W = 16;

    // 640x480@60 reset timing
    localparam int SG_DEF_HFP  = 16;
    localparam int SG_DEF_HPW  = 96;
    localparam int SG_DEF_HBP  = 48;
    localparam int SG_DEF_HACT = 640;
    localparam int SG_DEF_VFP  = 10;
    localparam int SG_DEF_VPW  = 2;
    localparam int SG_DEF_VBP  = 33;
    localparam int SG_DEF_VACT = 480;

    typedef struct packed {
        logic [TMG_W-1:0] hfp;
        logic [TMG_W-1:0] hpw;
        logic [TMG_W-1:0] hbp;
        logic [TMG_W-1:0] hact;
        logic [TMG_W-1:0] vfp;
        logic [TMG_W-1:0] vpw;
        logic [TMG_W-1:0] vbp;
        logic [TMG_W-1:0] vact;
        logic             hpol;
        logic             vpol;
    } timing_t;

endpackage

// File: rtl/syncgen_cfg.sv
// Timing shadow slot: validates offered sets, holds one pending set and
// releases it as a commit strobe when the generator reports a safe point.
module syncgen_cfg
    import syncgen_pkg::*;
#(
    parameter int CNT_W    = 11,
    parameter int PRE_LEAD = 1
) (
    input  logic    DCLK,
    input  logic    DRST_X,
    input  logic    cfg_valid,
    input  timing_t cfg_set,
    input  logic    commit_ok,
    output logic    cfg_ready,
    output logic    cfg_err,
    output logic    commit,
    output timing_t shadow
);

    // Wide enough that four maximum-size fields cannot wrap during validation
    localparam int            SW    = TMG_W + 2;
    localparam logic [SW-1:0] LIMIT = SW'(1) << CNT_W;

    logic          pending;
    logic          accept;
    logic          set_ok;
    logic [SW-1:0] hstart;
    logic [SW-1:0] hsc;
    logic [SW-1:0] vsc;

    always_comb begin
        hstart = SW'(cfg_set.hfp) + SW'(cfg_set.hpw) + SW'(cfg_set.hbp);
        hsc    = hstart + SW'(cfg_set.hact);
        vsc    = SW'(cfg_set.vfp) + SW'(cfg_set.vpw) + SW'(cfg_set.vbp) + SW'(cfg_set.vact);
        set_ok = (cfg_set.hpw != '0) && (cfg_set.hact != '0)
              && (cfg_set.vpw != '0) && (cfg_set.vact != '0)
              && (hsc < LIMIT) && (vsc < LIMIT)
              && (hstart >= SW'(PRE_LEAD));
    end

    assign cfg_ready = ~pending;
    assign accept    = cfg_valid & ~pending;
    assign commit    = pending & commit_ok;

    always_ff @(posedge DCLK) begin
        if (!DRST_X) begin
            pending <= 1'b0;
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= accept & ~set_ok;
            if (accept && set_ok) begin
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge DCLK) begin
        if (accept && set_ok) begin
            shadow <= cfg_set;
        end
    end

endmodule

// File: rtl/syncgen_prog.sv
// Programmable display sync generator: H/V counters, run/stop FSM and a
// registered sync/preDE decode of the position shown in the same cycle.
module syncgen_prog
    import syncgen_pkg::*;
#(
    parameter int CNT_W    = 11,
    parameter int PRE_LEAD = 1,
    parameter int DEF_HFP  = SG_DEF_HFP,
    parameter int DEF_HPW  = SG_DEF_HPW,
    parameter int DEF_HBP  = SG_DEF_HBP,
    parameter int DEF_HACT = SG_DEF_HACT,
    parameter int DEF_VFP  = SG_DEF_VFP,
    parameter int DEF_VPW  = SG_DEF_VPW,
    parameter int DEF_VBP  = SG_DEF_VBP,
    parameter int DEF_VACT = SG_DEF_VACT
) (
    input  logic             DCLK,
    input  logic             DRST_X,
    input  logic             RUN,
    input  logic             CFG_VALID,
    output logic             CFG_READY,
    input  logic [CNT_W-1:0] CFG_HFP,
    input  logic [CNT_W-1:0] CFG_HPW,
    input  logic [CNT_W-1:0] CFG_HBP,
    input  logic [CNT_W-1:0] CFG_HACT,
    input  logic [CNT_W-1:0] CFG_VFP,
    input  logic [CNT_W-1:0] CFG_VPW,
    input  logic [CNT_W-1:0] CFG_VBP,
    input  logic [CNT_W-1:0] CFG_VACT,
    input  logic             CFG_HPOL,
    input  logic             CFG_VPOL,
    output logic             CFG_ERR,
    output logic             DSP_HSYNC_X,
    output logic             DSP_VSYNC_X,
    output logic             DSP_preDE,
    output logic [CNT_W-1:0] HCNT,
    output logic [CNT_W-1:0] VCNT,
    output logic             FRAME_START,
    output logic             LINE_START
);

    localparam int DW = CNT_W + 1;

    localparam timing_t DEF_SET = '{
        hfp:  TMG_W'(DEF_HFP),  hpw:  TMG_W'(DEF_HPW),
        hbp:  TMG_W'(DEF_HBP),  hact: TMG_W'(DEF_HACT),
        vfp:  TMG_W'(DEF_VFP),  vpw:  TMG_W'(DEF_VPW),
        vbp:  TMG_W'(DEF_VBP),  vact: TMG_W'(DEF_VACT),
        hpol: 1'b0,             vpol: 1'b0
    };

    timing_t          cfg_set;
    timing_t          shadow;
    timing_t          act_p0;
    timing_t          nxt_set;
    sg_state_e        state_p0;
    sg_state_e        state_nxt;
    logic [CNT_W-1:0] hcnt_p0;
    logic [CNT_W-1:0] vcnt_p0;
    logic [CNT_W-1:0] hcnt_nxt;
    logic [CNT_W-1:0] vcnt_nxt;
    logic [DW-1:0]    hsc_act;
    logic [DW-1:0]    vsc_act;
    logic             line_end;
    logic             frame_end;
    logic             commit_ok;
    logic             commit;
    logic             active_nxt;
    logic [DW-1:0]    h, v;
    logic [DW-1:0]    hfp, hsw_end, hstart, hsc;
    logic [DW-1:0]    vfp, vsw_end, vstart, vsc;
    logic             hs_on, vs_on, de_on;
    logic             hsync_p0, vsync_p0, pre_de_p0, fs_p0, ls_p0;

    assign cfg_set = '{
        hfp:  TMG_W'(CFG_HFP),  hpw:  TMG_W'(CFG_HPW),
        hbp:  TMG_W'(CFG_HBP),  hact: TMG_W'(CFG_HACT),
        vfp:  TMG_W'(CFG_VFP),  vpw:  TMG_W'(CFG_VPW),
        vbp:  TMG_W'(CFG_VBP),  vact: TMG_W'(CFG_VACT),
        hpol: CFG_HPOL,         vpol: CFG_VPOL
    };

    syncgen_cfg #(
        .CNT_W    (CNT_W),
        .PRE_LEAD (PRE_LEAD)
    ) u_cfg (
        .DCLK      (DCLK),
        .DRST_X    (DRST_X),
        .cfg_valid (CFG_VALID),
        .cfg_set   (cfg_set),
        .commit_ok (commit_ok),
        .cfg_ready (CFG_READY),
        .cfg_err   (CFG_ERR),
        .commit    (commit),
        .shadow    (shadow)
    );

    assign hsc_act   = DW'(act_p0.hfp) + DW'(act_p0.hpw) + DW'(act_p0.hbp) + DW'(act_p0.hact);
    assign vsc_act   = DW'(act_p0.vfp) + DW'(act_p0.vpw) + DW'(act_p0.vbp) + DW'(act_p0.vact);
    assign line_end  = (state_p0 == SG_ACTIVE) && (DW'(hcnt_p0) == hsc_act - DW'(1));
    assign frame_end = line_end && (DW'(vcnt_p0) == vsc_act - DW'(1));
    // Timing may only change where the counters restart from 0
    assign commit_ok = (state_p0 == SG_IDLE) || frame_end;
    assign nxt_set   = commit ? shadow : act_p0;

    always_comb begin
        state_nxt = state_p0;
        hcnt_nxt  = hcnt_p0;
        vcnt_nxt  = vcnt_p0;
        unique case (state_p0)
            SG_ACTIVE: begin
                if (line_end) begin
                    hcnt_nxt = '0;
                    if (frame_end) begin
                        vcnt_nxt = '0;
                        if (!RUN) begin
                            state_nxt = SG_IDLE;
                        end
                    end else begin
                        vcnt_nxt = vcnt_p0 + 1'b1;
                    end
                end else begin
                    hcnt_nxt = hcnt_p0 + 1'b1;
                end
            end
            SG_IDLE: begin
                hcnt_nxt = '0;
                vcnt_nxt = '0;
                if (RUN) begin
                    state_nxt = SG_ACTIVE;
                end
            end
        endcase
    end

    // Decode the position and timing that will be visible after the next edge
    always_comb begin
        active_nxt = (state_nxt == SG_ACTIVE);
        h          = DW'(hcnt_nxt);
        v          = DW'(vcnt_nxt);
        hfp        = DW'(nxt_set.hfp);
        hsw_end    = hfp + DW'(nxt_set.hpw);
        hstart     = hsw_end + DW'(nxt_set.hbp);
        hsc        = hstart + DW'(nxt_set.hact);
        vfp        = DW'(nxt_set.vfp);
        vsw_end    = vfp + DW'(nxt_set.vpw);
        vstart     = vsw_end + DW'(nxt_set.vbp);
        vsc        = vstart + DW'(nxt_set.vact);
        hs_on      = (h >= hfp) && (h < hsw_end);
        vs_on      = ((v > vfp) || ((v == vfp) && (h >= hfp)))
                  && ((v < vsw_end) || ((v == vsw_end) && (h < hfp)));
        de_on      = (v >= vstart) && (v < vsc)
                  && (h >= hstart - DW'(PRE_LEAD)) && (h < hsc - DW'(PRE_LEAD));
    end

    // Stage p0: counters, active timing and outputs register together
    always_ff @(posedge DCLK) begin
        if (!DRST_X) begin
            state_p0  <= SG_ACTIVE;
            hcnt_p0   <= '0;
            vcnt_p0   <= '0;
            act_p0    <= DEF_SET;
            hsync_p0  <= 1'b1;
            vsync_p0  <= 1'b1;
            pre_de_p0 <= 1'b0;
            fs_p0     <= 1'b1;
            ls_p0     <= 1'b1;
        end else begin
            state_p0  <= state_nxt;
            hcnt_p0   <= hcnt_nxt;
            vcnt_p0   <= vcnt_nxt;
            act_p0    <= nxt_set;
            hsync_p0  <= (active_nxt && hs_on) ? nxt_set.hpol : ~nxt_set.hpol;
            vsync_p0  <= (active_nxt && vs_on) ? nxt_set.vpol : ~nxt_set.vpol;
            pre_de_p0 <= active_nxt && de_on;
            fs_p0     <= active_nxt && (hcnt_nxt == '0) && (vcnt_nxt == '0);
            ls_p0     <= active_nxt && (hcnt_nxt == '0);
        end
    end

    assign HCNT        = hcnt_p0;
    assign VCNT        = vcnt_p0;
    assign DSP_HSYNC_X = hsync_p0;
    assign DSP_VSYNC_X = vsync_p0;
    assign DSP_preDE   = pre_de_p0;
    assign FRAME_START = fs_p0;
    assign LINE_START  = ls_p0;

endmodule

// File: tb/tb_syncgen_prog.sv
// Directed bench for syncgen_prog using a reduced default timing so whole frames stay short.
module tb_syncgen_prog;

    localparam int CNT_W = 11;

    logic             DCLK = 1'b0;
    logic             DRST_X;
    logic             RUN;
    logic             CFG_VALID;
    logic             CFG_READY;
    logic [CNT_W-1:0] CFG_HFP, CFG_HPW, CFG_HBP, CFG_HACT;
    logic [CNT_W-1:0] CFG_VFP, CFG_VPW, CFG_VBP, CFG_VACT;
    logic             CFG_HPOL, CFG_VPOL;
    logic             CFG_ERR;
    logic             DSP_HSYNC_X, DSP_VSYNC_X, DSP_preDE;
    logic [CNT_W-1:0] HCNT, VCNT;
    logic             FRAME_START, LINE_START;

    always #5 DCLK = ~DCLK;

    // Defaults: HSC 35 (HSYNC 4..9, preDE 13..32), VSC 15 (VSYNC (2,4)..(4,4), preDE rows >= 7)
    syncgen_prog #(
        .CNT_W(CNT_W), .PRE_LEAD(2),
        .DEF_HFP(4), .DEF_HPW(6), .DEF_HBP(5), .DEF_HACT(20),
        .DEF_VFP(2), .DEF_VPW(2), .DEF_VBP(3), .DEF_VACT(8)
    ) dut (
        .DCLK(DCLK), .DRST_X(DRST_X), .RUN(RUN),
        .CFG_VALID(CFG_VALID), .CFG_READY(CFG_READY),
        .CFG_HFP(CFG_HFP), .CFG_HPW(CFG_HPW), .CFG_HBP(CFG_HBP), .CFG_HACT(CFG_HACT),
        .CFG_VFP(CFG_VFP), .CFG_VPW(CFG_VPW), .CFG_VBP(CFG_VBP), .CFG_VACT(CFG_VACT),
        .CFG_HPOL(CFG_HPOL), .CFG_VPOL(CFG_VPOL), .CFG_ERR(CFG_ERR),
        .DSP_HSYNC_X(DSP_HSYNC_X), .DSP_VSYNC_X(DSP_VSYNC_X), .DSP_preDE(DSP_preDE),
        .HCNT(HCNT), .VCNT(VCNT), .FRAME_START(FRAME_START), .LINE_START(LINE_START)
    );

    int n_chk = 0;
    int n_err = 0;

    int rej [4][8] = '{
        '{4, 0, 4, 32,   4, 2, 4, 12},
        '{4, 2, 4, 2040, 4, 2, 4, 12},
        '{0, 1, 0, 32,   4, 2, 4, 12},
        '{4, 2, 4, 32,   4, 2, 4, 0}
    };

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) @(negedge DCLK);
    endtask

    task automatic goto(input int h, input int v);
        int n = 0;
        while (!(HCNT == h && VCNT == v) && n < 3000) begin
            @(negedge DCLK);
            n++;
        end
        if (n >= 3000)
            chk_val($sformatf("reach_v%0d_h%0d", v, h), {5'd0, VCNT, 5'd0, HCNT},
                    (v << 16) | h);
    endtask

    task automatic offer(input int hfp, input int hpw, input int hbp, input int hact,
                         input int vfp, input int vpw, input int vbp, input int vact,
                         input logic hp, input logic vp);
        CFG_HFP  = CNT_W'(hfp);  CFG_HPW = CNT_W'(hpw);
        CFG_HBP  = CNT_W'(hbp);  CFG_HACT = CNT_W'(hact);
        CFG_VFP  = CNT_W'(vfp);  CFG_VPW = CNT_W'(vpw);
        CFG_VBP  = CNT_W'(vbp);  CFG_VACT = CNT_W'(vact);
        CFG_HPOL = hp;           CFG_VPOL = vp;
        CFG_VALID = 1'b1;
        step();
        CFG_VALID = 1'b0;
    endtask

    task automatic scan_line(input int v, input int hsc, output int hs_lo, output int de_hi);
        goto(0, v);
        hs_lo = 0;
        de_hi = 0;
        for (int i = 0; i < hsc; i++) begin
            if (DSP_HSYNC_X == 1'b0) hs_lo++;
            if (DSP_preDE == 1'b1) de_hi++;
            step();
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs_lo, de_hi;
        DRST_X = 1'b0; RUN = 1'b1; CFG_VALID = 1'b0;
        CFG_HFP = '0; CFG_HPW = '0; CFG_HBP = '0; CFG_HACT = '0;
        CFG_VFP = '0; CFG_VPW = '0; CFG_VBP = '0; CFG_VACT = '0;
        CFG_HPOL = 1'b0; CFG_VPOL = 1'b0;

        // Reset values, still visible in the first cycle after release
        step(3);
        chk_val("rst_hcnt", HCNT, 0);
        chk_val("rst_vcnt", VCNT, 0);
        chk_val("rst_hsync", DSP_HSYNC_X, 1);
        chk_val("rst_vsync", DSP_VSYNC_X, 1);
        chk_val("rst_prede", DSP_preDE, 0);
        chk_val("rst_ready", CFG_READY, 1);
        chk_val("rst_err", CFG_ERR, 0);
        chk_val("rst_fs", FRAME_START, 1);
        chk_val("rst_ls", LINE_START, 1);
        DRST_X = 1'b1;
        step();
        chk_val("run_hcnt1", HCNT, 1);
        chk_val("run_fs0", FRAME_START, 0);

        // Default timing, frame 1
        goto(34, 0); step();
        chk_val("def_wrap_h", HCNT, 0);
        chk_val("def_wrap_v", VCNT, 1);
        chk_val("def_ls", LINE_START, 1);
        chk_val("def_ls_fs", FRAME_START, 0);
        goto(3, 1);  chk_val("def_hs_h3", DSP_HSYNC_X, 1);
        step();      chk_val("def_hs_h4", DSP_HSYNC_X, 0);
        goto(9, 1);  chk_val("def_hs_h9", DSP_HSYNC_X, 0);
        step();      chk_val("def_hs_h10", DSP_HSYNC_X, 1);
        goto(3, 2);  chk_val("def_vs_2_3", DSP_VSYNC_X, 1);
        step();      chk_val("def_vs_2_4", DSP_VSYNC_X, 0);
        goto(3, 4);  chk_val("def_vs_4_3", DSP_VSYNC_X, 0);
        step();      chk_val("def_vs_4_4", DSP_VSYNC_X, 1);
        goto(20, 6); chk_val("def_de_row6", DSP_preDE, 0);
        scan_line(7, 35, hs_lo, de_hi);
        chk_val("def_hs_width", hs_lo, 6);
        chk_val("def_de_width", de_hi, 20);
        goto(12, 8); chk_val("def_de_h12", DSP_preDE, 0);
        step();      chk_val("def_de_h13", DSP_preDE, 1);
        goto(32, 8); chk_val("def_de_h32", DSP_preDE, 1);
        step();      chk_val("def_de_h33", DSP_preDE, 0);
        goto(34, 14); step();
        chk_val("def_frame_v", VCNT, 0);
        chk_val("def_frame_fs", FRAME_START, 1);

        // Mid-frame accept: HSC 42, VSC 22, HSYNC high-active 4..5, preDE 8..39 on rows >= 10
        goto(5, 3);
        offer(4, 2, 4, 32, 4, 2, 4, 12, 1'b1, 1'b0);
        chk_val("acc_ready_drop", CFG_READY, 0);
        goto(34, 14);
        chk_val("acc_ready_pend", CFG_READY, 0);
        step();
        chk_val("acc_commit_fs", FRAME_START, 1);
        chk_val("acc_ready_back", CFG_READY, 1);
        chk_val("acc_hs_idle_pol", DSP_HSYNC_X, 0);
        goto(41, 0); step();
        chk_val("acc_hsc_v", VCNT, 1);
        chk_val("acc_hsc_h", HCNT, 0);
        goto(3, 1);  chk_val("acc_hs_h3", DSP_HSYNC_X, 0);
        step();      chk_val("acc_hs_h4", DSP_HSYNC_X, 1);
        goto(5, 1);  chk_val("acc_hs_h5", DSP_HSYNC_X, 1);
        step();      chk_val("acc_hs_h6", DSP_HSYNC_X, 0);
        goto(3, 4);  chk_val("acc_vs_4_3", DSP_VSYNC_X, 1);
        step();      chk_val("acc_vs_4_4", DSP_VSYNC_X, 0);
        goto(7, 10); chk_val("acc_de_h7", DSP_preDE, 0);
        step();      chk_val("acc_de_h8", DSP_preDE, 1);
        goto(39, 10); chk_val("acc_de_h39", DSP_preDE, 1);
        step();      chk_val("acc_de_h40", DSP_preDE, 0);

        // Rejected sets: zero HPW, HSC of 2050, HSTART below the preDE lead, zero VACT
        goto(0, 12);
        for (int i = 0; i < 4; i++) begin
            offer(rej[i][0], rej[i][1], rej[i][2], rej[i][3],
                  rej[i][4], rej[i][5], rej[i][6], rej[i][7], 1'b0, 1'b1);
            chk_val($sformatf("rej%0d_err", i), CFG_ERR, 1);
            chk_val($sformatf("rej%0d_ready", i), CFG_READY, 1);
            step();
            chk_val($sformatf("rej%0d_err_end", i), CFG_ERR, 0);
        end

        // Accept in the frame-end cycle: commit waits one full frame
        goto(41, 21);
        offer(4, 6, 5, 20, 2, 2, 3, 8, 1'b0, 1'b0);
        chk_val("fe_frame_v", VCNT, 0);
        chk_val("fe_ready_pend", CFG_READY, 0);
        chk_val("fe_old_pol", DSP_HSYNC_X, 0);
        goto(41, 0); step();
        chk_val("fe_old_hsc", VCNT, 1);
        goto(41, 21);
        chk_val("fe_ready_still", CFG_READY, 0);
        step();
        chk_val("fe_commit_ready", CFG_READY, 1);
        chk_val("fe_new_pol", DSP_HSYNC_X, 1);
        goto(34, 0); step();
        chk_val("fe_new_hsc_v", VCNT, 1);
        chk_val("fe_new_hsc_h", HCNT, 0);

        // RUN drop mid-frame, then restart
        goto(0, 5);
        RUN = 1'b0;
        step();
        chk_val("stop_still_run", HCNT, 1);
        goto(34, 14); step();
        chk_val("idle_h", HCNT, 0);
        chk_val("idle_v", VCNT, 0);
        chk_val("idle_fs", FRAME_START, 0);
        chk_val("idle_ls", LINE_START, 0);
        chk_val("idle_hs", DSP_HSYNC_X, 1);
        chk_val("idle_vs", DSP_VSYNC_X, 1);
        chk_val("idle_de", DSP_preDE, 0);
        step(5);
        chk_val("idle_hold_h", HCNT, 0);
        RUN = 1'b1;
        step();
        chk_val("restart_fs", FRAME_START, 1);
        chk_val("restart_ls", LINE_START, 1);
        chk_val("restart_h", HCNT, 0);
        step();
        chk_val("restart_h1", HCNT, 1);

        // Reset mid-frame with a set pending
        goto(20, 3);
        offer(4, 2, 4, 32, 4, 2, 4, 12, 1'b1, 1'b0);
        chk_val("rstp_ready_pend", CFG_READY, 0);
        goto(30, 3);
        DRST_X = 1'b0;
        step();
        chk_val("rstp_h", HCNT, 0);
        chk_val("rstp_v", VCNT, 0);
        chk_val("rstp_ready", CFG_READY, 1);
        chk_val("rstp_fs", FRAME_START, 1);
        chk_val("rstp_hs", DSP_HSYNC_X, 1);
        DRST_X = 1'b1;
        goto(34, 0); step();
        chk_val("rstp_def_hsc", VCNT, 1);
        goto(34, 14); step();
        chk_val("rstp_frame_fs", FRAME_START, 1);
        goto(34, 0); step();
        chk_val("rstp_discard_v", VCNT, 1);
        chk_val("rstp_discard_h", HCNT, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
